// File: rtl/muldiv_if.sv
// Execute-stage <-> mul/div sequencer bundle: request, flush, status and HI/LO.
// The master drives requests; the sequencer (slave) owns status and HI/LO.
interface muldiv_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, a, b, flush,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, a, b, flush,
        output op_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply / restoring-divide sequencer that owns HI/LO.
// MULT* complete after MUL_LAT cycles, DIV* after 32 steps plus a sign-fix cycle.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] MUL_CNT0 = 5'(MUL_LAT - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        is_signed;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Sign-extend when signed; the low 64 bits of the product are then exact.
    function automatic logic [63:0] mul64(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        s
    );
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{s & x[31]}}, x};
        ye = {{32{s & y[31]}}, y};
        return xe * ye;
    endfunction

    logic        req_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod_now;
    logic [63:0] prod_lat;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign req_signed = ~bus.op[0];
    assign abs_a      = (req_signed & bus.a[31]) ? -bus.a : bus.a;
    assign abs_b      = (req_signed & bus.b[31]) ? -bus.b : bus.b;
    assign prod_now   = mul64(bus.a, bus.b, req_signed);
    assign prod_lat   = mul64(op_a, op_b, is_signed);

    assign rem_sh = {rem, quo[31]};
    assign trial  = rem_sh - {1'b0, op_b};
    assign q_fix  = (is_signed & (sign_a ^ sign_b)) ? -quo : quo;
    assign r_fix  = (is_signed & sign_a) ? -rem : rem;

    assign bus.op_ready = rst_n & (state == IDLE) & ~bus.flush;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rem       <= '0;
            quo       <= '0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.op_valid) begin
                            unique case (1'b1)
                                (bus.op == OP_MTHI): hi_q <= bus.a;
                                (bus.op == OP_MTLO): lo_q <= bus.a;
                                (bus.op == OP_MULT),
                                (bus.op == OP_MULTU): begin
                                    op_a      <= bus.a;
                                    op_b      <= bus.b;
                                    is_signed <= req_signed;
                                    if (MUL_LAT == 1) begin
                                        {hi_q, lo_q} <= prod_now;
                                        done_q       <= 1'b1;
                                    end else begin
                                        cnt   <= MUL_CNT0;
                                        state <= MUL;
                                    end
                                end
                                (bus.op == OP_DIV),
                                (bus.op == OP_DIVU): begin
                                    if (bus.b == '0) begin
                                        hi_q   <= bus.a;
                                        lo_q   <= '1;
                                        done_q <= 1'b1;
                                    end else begin
                                        quo       <= abs_a;
                                        op_b      <= abs_b;
                                        rem       <= '0;
                                        cnt       <= '0;
                                        is_signed <= req_signed;
                                        sign_a    <= bus.a[31];
                                        sign_b    <= bus.b[31];
                                        state     <= DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt <= 5'd1) begin
                            {hi_q, lo_q} <= prod_lat;
                            done_q       <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    DIV: begin
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= FIX;
                    end
                    FIX: begin
                        hi_q   <= r_fix;
                        lo_q   <= q_fix;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO per mul/div.
// Expected results come from a behavioural model using native SV arithmetic.
module tb_muldiv_ctrl;

    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    logic [63:0] sb_q[$];

    muldiv_if bus ();

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [63:0] model(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic [63:0]        r;
        sa  = $signed(a);
        sbv = $signed(b);
        qa  = $signed(a);
        qb  = $signed(b);
        r   = 64'd0;
        case (op)
            3'd0: r = sa * sbv;
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    r = {32'd0, 32'h80000000};
                else
                    r = {32'(qa % qb), 32'(qa / qb)};
            end
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Issues one mul/div, waits for done, checks latency, busy span and HI/LO.
    // Returns in the cycle done is high.
    task automatic run_op(
        input string       name,
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input int          lat
    );
        int          t;
        int          nbusy;
        logic [63:0] exp;
        sb_q.push_back(model(op, a, b));
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        step();
        idle_inputs();
        t     = 1;
        nbusy = 0;
        while (!bus.done && t < 60) begin
            if (bus.busy) nbusy++;
            step();
            t++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, t);
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            if (t !== lat) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name, t, lat);
            end
            checks++;
            if (nbusy !== lat - 1) begin
                errors++;
                $display("FAIL %s busy cycles got %0d want %0d",
                         name, nbusy, lat - 1);
            end
            checks++;
            if ({bus.hi, bus.lo} !== exp) begin
                errors++;
                $display("FAIL %s hi/lo got %h_%h want %h_%h",
                         name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic check_done_low(input string name);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done got %b want 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.op_ready} !== 67'd0) begin
            errors++;
            $display("FAIL reset hi=%h lo=%h busy=%b done=%b rdy=%b want zeros",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.op_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release op_ready got %b want 1", bus.op_ready);
        end
    endtask

    task automatic test_mthi_mtlo();
        bus.op_valid = 1'b1;
        bus.op       = 3'd4;
        bus.a        = 32'h12345678;
        step();
        checks++;
        if (bus.hi !== 32'h12345678 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi hi=%h done=%b want 12345678/0", bus.hi, bus.done);
        end
        bus.op = 3'd5;
        bus.a  = 32'h9ABCDEF0;
        step();
        idle_inputs();
        checks++;
        if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mtlo hi=%h lo=%h want 12345678/9abcdef0",
                     bus.hi, bus.lo);
        end
        check_done_low("mtlo");
        step();
        check_done_low("mt_after");
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mt_busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reserved();
        logic [63:0] prev;
        prev         = {bus.hi, bus.lo};
        bus.op_valid = 1'b1;
        bus.op       = 3'd6;
        bus.a        = 32'hCAFEBABE;
        step();
        idle_inputs();
        checks++;
        if ({bus.hi, bus.lo} !== prev || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reserved hi=%h lo=%h busy=%b want %h busy 0",
                     bus.hi, bus.lo, bus.busy, prev);
        end
        check_done_low("reserved");
    endtask

    task automatic test_mul();
        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, LAT);
        step();
        check_done_low("mult_pulse");
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, LAT);
        step();
        check_done_low("multu_pulse");
        run_op("mult_big", 3'd0, 32'h80000000, 32'h80000000, LAT);
        step();
    endtask

    task automatic test_div();
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 34);
        step();
        check_done_low("div_pulse");
        run_op("divu", 3'd3, 32'd7, 32'd2, 34);
        step();
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 34);
        step();
        run_op("divu_zero", 3'd3, 32'd5, 32'd0, 1);
        step();
        check_done_low("divz_pulse");
        run_op("div_mixed", 3'd2, 32'd100, 32'hFFFFFFF9, 34);
        step();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_multu", 3'd1, 32'h0001_0000, 32'h0001_0000, LAT);
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b op_ready in done cycle got %b want 1",
                     bus.op_ready);
        end
        run_op("b2b_divu", 3'd3, 32'hFFFFFFFF, 32'd10, 34);
        run_op("b2b_mult", 3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, LAT);
        step();
        check_done_low("b2b_pulse");
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        prev         = {bus.hi, bus.lo};
        bus.op_valid = 1'b1;
        bus.op       = 3'd2;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        step();
        idle_inputs();
        for (int i = 0; i < 19; i++) step();
        bus.flush    = 1'b1;
        bus.op_valid = 1'b1;
        bus.op       = 3'd5;
        bus.a        = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.op_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush op_ready got %b want 0", bus.op_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== prev) begin
            errors++;
            $display("FAIL flush busy=%b hi=%h lo=%h want 0 %h",
                     bus.busy, bus.hi, bus.lo, prev);
        end
        for (int i = 0; i < 15; i++) begin
            check_done_low("flush_nodone");
            step();
        end
        checks++;
        if ({bus.hi, bus.lo} !== prev) begin
            errors++;
            $display("FAIL flush_hold hi=%h lo=%h want %h", bus.hi, bus.lo, prev);
        end
        run_op("divu_after_flush", 3'd3, 32'd100, 32'd7, 34);
        step();
    endtask

    task automatic test_reset_mid_div();
        bus.op_valid = 1'b1;
        bus.op       = 3'd2;
        bus.a        = 32'd1000;
        bus.b        = 32'd3;
        step();
        idle_inputs();
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.op_ready} !== 67'd0) begin
            errors++;
            $display("FAIL midreset hi=%h lo=%h busy=%b done=%b rdy=%b want zeros",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.op_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release op_ready got %b want 1",
                     bus.op_ready);
        end
        run_op("div_after_reset", 3'd2, 32'hFFFFFC18, 32'd3, 34);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_mthi_mtlo();
        test_reserved();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
